// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//   IF stage of the five-stage pipeline. Owns the PC, issues at most one
//   instruction-memory request at a time and holds the fetched word in the
//   IF/ID register for instr_decode. Decode back-pressure stalls the stage;
//   a redirect from EX flushes IF/ID and retargets the PC. A fetch that is
//   already in flight when the redirect arrives is allowed to finish, and its
//   response is thrown away.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr instruction-memory request channel
//   imem_resp_valid/data            instruction-memory response channel
//   id_ready                        decode consumes IF/ID this cycle
//   redirect_valid/pc               taken branch/jump from EX
//   if_id_valid/instr/pc/pc4        IF/ID register contents
//   fetch_misalign                  present only with FETCH_MISALIGN_TRAP_EN
//
// Build option
//   FETCH_MISALIGN_TRAP_EN : a misaligned redirect places a NOP marked with
//   the bad PC in IF/ID, raises fetch_misalign and halts fetching until the
//   next aligned redirect. Without it, redirect_pc[1:0] is ignored.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;

    logic [31:0] redir_tgt;
    logic        fetch_ok;
    logic        resp_done;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic        redir_mis;

    assign redir_tgt = redirect_pc;
    assign redir_mis = |redirect_pc[1:0];
    assign fetch_ok  = !misalign_q;
`else
    logic        unused_redirect_lsb;

    assign redir_tgt           = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fetch_ok            = 1'b1;
`endif

    assign resp_done = (state_q == ST_WAIT) && imem_resp_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif

        // The address is latched when the request is raised so that a
        // redirect while the request waits for ready cannot move it.
        unique case (state_q)
            ST_IDLE: begin
                if ((!valid_q || id_ready) && !redirect_valid && fetch_ok) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                end
            end
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completing transaction always clears drop: nothing is left in
        // flight, even if a redirect lands on the same cycle.
        if (resp_done) begin
            drop_d = 1'b0;
        end else if (redirect_valid && (state_q != ST_IDLE)) begin
            drop_d = 1'b1;
        end

        if (redirect_valid) begin
            pc_d    = redir_tgt;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d = redir_mis;
            if (redir_mis) begin
                valid_d = 1'b1;
                ifpc_d  = redirect_pc;
                ifpc4_d = redirect_pc + 32'd4;
            end
`endif
        end else if (resp_done && !drop_q) begin
            valid_d = 1'b1;
            instr_d = imem_resp_data;
            ifpc_d  = pc_q;
            ifpc4_d = pc_q + 32'd4;
            pc_d    = pc_q + 32'd4;
        end else if (valid_q && id_ready) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'd0;
            ifpc4_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`endif

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_addr      = addr_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ifpc_q;
    assign if_id_pc4      = ifpc4_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    instr_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the next PC that decode must see, plus an imem
    // behavioural model with one outstanding transaction.
    logic [31:0] exp_pc;
    bit          outst;
    int          lat;
    logic [31:0] out_addr;
    bit          pend;
    logic [31:0] pend_addr;
    bit          prev_stall;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    int          n_deliv;
    int          n_acc;
    logic [31:0] last_acc;
    bit          chk_stream;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // registered outputs against the model, then advance the model.
    task automatic cycle(input int p_rdy, input int p_idr, input int p_redir,
                         input int max_lat, input bit force_redir,
                         input logic [31:0] tgt);
        logic [31:0] rtgt;
        bit          req_v;
        logic [31:0] req_a;
        bit          rsp_v;

        imem_req_ready  = ($urandom_range(99) < p_rdy);
        imem_resp_valid = outst && (lat == 0);
        imem_resp_data  = imem_resp_valid ? mem(out_addr) : $urandom;
        id_ready        = ($urandom_range(99) < p_idr);
        redirect_valid  = force_redir || ($urandom_range(99) < p_redir);
        rtgt = $urandom & 32'h0000_FFFF;
        if ($urandom_range(3) == 0) rtgt = 32'hFFFF_FFF0 | (rtgt & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
        rtgt = rtgt & ~32'h3;
`endif
        if (force_redir) rtgt = tgt;
        redirect_pc = rtgt;

        if (pend) begin
            chk("req_held", {31'd0, imem_req_valid}, 32'd1);
            chk("addr_held", imem_addr, pend_addr);
        end
        if (imem_req_valid) begin
            chk("req_only_when_free", {31'd0, if_id_valid}, 32'd0);
            chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        if (outst) chk("one_outstanding", {31'd0, imem_req_valid}, 32'd0);
        if (!if_id_valid) chk("nop_when_invalid", if_id_instr, NOP);
        else              chk("pc4", if_id_pc4, if_id_pc + 32'd4);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
            chk("stall_instr", if_id_instr, prev_instr);
            chk("stall_pc", if_id_pc, prev_pc);
        end
        if (chk_stream && if_id_valid) begin
            chk("stream_pc", if_id_pc, exp_pc);
            chk("stream_instr", if_id_instr, mem(exp_pc));
        end

        if (if_id_valid && id_ready && !redirect_valid) begin
            n_deliv++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = rtgt & ~32'h3;
        prev_stall = if_id_valid && !id_ready && !redirect_valid;
        prev_instr = if_id_instr;
        prev_pc    = if_id_pc;

        req_v = imem_req_valid;
        req_a = imem_addr;
        rsp_v = imem_resp_valid;
        @(posedge clk);
        if (req_v && imem_req_ready) begin
            outst    = 1'b1;
            out_addr = req_a;
            lat      = $urandom_range(max_lat);
            pend     = 1'b0;
            n_acc++;
            last_acc = req_a;
        end else begin
            pend      = req_v;
            pend_addr = req_a;
            if (outst) begin
                if (rsp_v) outst = 1'b0;
                else       lat--;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_pc     = 32'h0;
        outst      = 1'b0;
        lat        = 0;
        pend       = 1'b0;
        prev_stall = 1'b0;
        chk_stream = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_if_id_instr"}, if_id_instr, NOP);
        chk({tag, "_if_id_pc"}, if_id_pc, 32'd0);
        chk({tag, "_if_id_pc4"}, if_id_pc4, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_misalign"}, {31'd0, fetch_misalign}, 32'd0);
`endif
    endtask

    initial begin
        int  d0;
        int  a0;
        bit  found;

        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        n_deliv         = 0;
        n_acc           = 0;
        last_acc        = 32'hDEAD_BEEF;
        model_reset();

        // Reset values, then sequential fetch at full speed.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (15) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("first_fetch_addr", n_acc > 0 ? 32'h0 : 32'hFFFF_FFFF, 32'h0);
        chk("seq_pc_after_15", exp_pc >= 32'd12 ? 32'd1 : 32'd0, 32'd1);

        // Decode stall for five cycles with a live entry.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (if_id_valid) found = 1'b1;
            else cycle(100, 100, 0, 0, 1'b0, 32'h0);
        end
        chk("stall_reach_valid", {31'd0, found}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            cycle(100, 0, 0, 0, 1'b0, 32'h0);
        end
        d0 = n_deliv;
        repeat (10) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("stall_resume", n_deliv > d0 ? 32'd1 : 32'd0, 32'd1);

        // Redirect to 0x100 while a response is still pending.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (outst && lat > 0) begin
                found = 1'b1;
                cycle(100, 100, 0, 2, 1'b1, 32'h0000_0100);
            end else begin
                cycle(100, 100, 0, 2, 1'b0, 32'h0);
            end
        end
        chk("redir_wait_reached", {31'd0, found}, 32'd1);
        d0 = n_deliv;
        repeat (15) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("redir_wait_progress", n_deliv > d0 ? 32'd1 : 32'd0, 32'd1);

        // Redirect coinciding with the response.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (outst && lat == 0) begin
                found = 1'b1;
                a0 = n_acc;
                cycle(100, 100, 0, 0, 1'b1, 32'h0000_0300);
            end else begin
                cycle(100, 100, 0, 0, 1'b0, 32'h0);
            end
        end
        chk("redir_resp_reached", {31'd0, found}, 32'd1);
        for (int i = 0; i < 10 && n_acc == a0; i++) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("redir_resp_next_addr", last_acc, 32'h0000_0300);

        // Randomized traffic: ready, latency, stalls and redirects.
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            cycle(70, 70, 4, 3, 1'b0, 32'h0);
        end
        chk("random_progress", n_deliv - d0 > 100 ? 32'd1 : 32'd0, 32'd1);

        // Asynchronous reset while waiting for a response.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (outst) found = 1'b1;
            else cycle(100, 100, 0, 3, 1'b0, 32'h0);
        end
        chk("midwait_reached", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc == a0; i++) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("restart_addr", last_acc, 32'h0);
        d0 = n_deliv;
        repeat (10) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("restart_progress", n_deliv > d0 ? 32'd1 : 32'd0, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps fetching until an aligned redirect.
        chk_stream = 1'b0;
        cycle(100, 0, 0, 0, 1'b1, 32'h0000_0102);
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_valid", {31'd0, if_id_valid}, 32'd1);
        chk("mis_instr", if_id_instr, NOP);
        chk("mis_pc", if_id_pc, 32'h0000_0102);
        repeat (4) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
            cycle(100, 100, 0, 0, 1'b0, 32'h0);
        end
        chk_stream = 1'b1;
        cycle(100, 100, 0, 0, 1'b1, 32'h0000_0200);
        chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc == a0; i++) cycle(100, 100, 0, 0, 1'b0, 32'h0);
        chk("mis_resume_addr", last_acc, 32'h0000_0200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
